// File: rtl/key_cache_loader.sv
// Loads a 128-bit master key into the cache as four words, then appends expanded
// words derived from a sliding 4-word window, one cache write per cycle.
module key_cache_loader #(
  parameter int ADDR_W    = 6,
  parameter int NUM_WORDS = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [127:0]      master_key,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [31:0]       cache_data,
  output logic              cache_we,
  output logic              busy,
  output logic              done,
  output logic [6:0]        words_written
);

  generate
    if (NUM_WORDS < 4 || NUM_WORDS > 64) begin : g_bad_num_words
      $error("key_cache_loader: NUM_WORDS must be in 4..64");
    end
    if (BASE_ADDR < 0 || BASE_ADDR + NUM_WORDS > (1 << ADDR_W)) begin : g_bad_range
      $error("key_cache_loader: BASE_ADDR+NUM_WORDS exceeds cache depth");
    end
  endgenerate

  localparam logic [6:0] LAST_IDX = 7'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  state_t              state_q, state_d;
  logic [6:0]          idx_q, idx_d;
  logic [31:0]         win_q [4];
  logic [31:0]         win_d [4];
  logic                key_ready_q, key_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [6:0]          ww_q, ww_d;
  logic [6:0]          next_idx;
  logic [31:0]         expanded;

  function automatic logic [31:0] rotl8(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // idx_q is the index of the word currently on the write port; the window holds
  // w[idx-3..idx] once expansion starts (w0..w3 throughout LOAD).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    win_d       = win_q;
    key_ready_d = key_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    ww_d        = we_q ? ww_q + 7'd1 : ww_q;
    next_idx    = idx_q + 7'd1;
    expanded    = win_q[0] ^ rotl8(win_q[3]) ^ {25'd0, next_idx};

    case (state_q)
      IDLE: begin
        if (key_valid && key_ready_q) begin
          state_d     = LOAD;
          idx_d       = 7'd0;
          win_d[0]    = master_key[127:96];
          win_d[1]    = master_key[95:64];
          win_d[2]    = master_key[63:32];
          win_d[3]    = master_key[31:0];
          we_d        = 1'b1;
          addr_d      = ADDR_W'(BASE_ADDR);
          data_d      = master_key[127:96];
          key_ready_d = 1'b0;
          busy_d      = 1'b1;
          ww_d        = 7'd0;
        end
      end
      LOAD, EXPAND: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d  = next_idx;
          we_d   = 1'b1;
          addr_d = ADDR_W'(BASE_ADDR + int'(next_idx));
          if (next_idx < 7'd4) begin
            state_d = LOAD;
            data_d  = win_q[next_idx[1:0]];
          end else begin
            state_d  = EXPAND;
            data_d   = expanded;
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = win_q[3];
            win_d[3] = expanded;
          end
        end
      end
      DONE: begin
        state_d     = IDLE;
        key_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 7'd0;
      for (int i = 0; i < 4; i++) win_q[i] <= 32'd0;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= 32'd0;
      ww_q        <= 7'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      win_q       <= win_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ww_q        <= ww_d;
    end
  end

  assign key_ready     = key_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cache_we      = we_q;
  assign cache_addr    = addr_q;
  assign cache_data    = data_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_key_cache_loader.sv
// Scoreboard bench: drivers push expected cache writes / done pulses, a negedge
// monitor pops and compares them against two loader instances.
module tb_key_cache_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         kv0, kv1, kr0, kr1;
  logic [127:0] mk0, mk1;
  logic [5:0]   addr0, addr1;
  logic [31:0]  data0, data1;
  logic         we0, we1, busy0, busy1, done0, done1;
  logic [6:0]   ww0, ww1;

  key_cache_loader #(.ADDR_W(6), .NUM_WORDS(16), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .key_valid(kv0), .key_ready(kr0), .master_key(mk0),
    .cache_addr(addr0), .cache_data(data0), .cache_we(we0), .busy(busy0),
    .done(done0), .words_written(ww0));

  key_cache_loader #(.ADDR_W(6), .NUM_WORDS(4), .BASE_ADDR(60)) dut1 (
    .clk(clk), .rst(rst), .key_valid(kv1), .key_ready(kr1), .master_key(mk1),
    .cache_addr(addr1), .cache_data(data1), .cache_we(we1), .busy(busy1),
    .done(done1), .words_written(ww1));

  typedef struct packed {
    logic [31:0] cyc;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        d;
  } wr_t;

  wr_t         wq[$];
  wr_t         dq[$];
  logic [31:0] mem [64];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference model: full word array computed straight from the expansion formula.
  task automatic model_push(input bit d, input logic [127:0] k, input int t);
    logic [31:0] w [64];
    int n;
    int base;
    n    = d ? 4 : 16;
    base = d ? 60 : 0;
    w[0] = k[127:96];
    w[1] = k[95:64];
    w[2] = k[63:32];
    w[3] = k[31:0];
    for (int i = 4; i < n; i++)
      w[i] = w[i-4] ^ {w[i-1][23:0], w[i-1][31:24]} ^ 32'(i);
    for (int i = 0; i < n; i++)
      wq.push_back('{cyc: 32'(t + 1 + i), addr: 6'(base + i), data: w[i], d: d});
    dq.push_back('{cyc: 32'(t + 1 + n), addr: 6'd0, data: 32'(n), d: d});
  endtask

  always @(negedge clk) begin : monitor
    wr_t         e;
    bit          d;
    logic [5:0]  a;
    logic [31:0] v;
    if (we0 || we1) begin
      check("single_writer", 128'(we0 && we1), 128'(0));
      d = we1;
      a = d ? addr1 : addr0;
      v = d ? data1 : data0;
      $display("write dut%0d cycle %0d addr %0d data %08h", d, cyc, a, v);
      check("write_expected", 128'(wq.size() != 0), 128'(1));
      if (wq.size() != 0) begin
        e = wq.pop_front();
        check("write_cycle", 128'(cyc), 128'(e.cyc));
        check("write_dut", 128'(d), 128'(e.d));
        check("write_addr", 128'(a), 128'(e.addr));
        check("write_data", 128'(v), 128'(e.data));
      end
      mem[a] = v;
    end
    if (done0 || done1) begin
      d = done1;
      $display("done dut%0d cycle %0d words_written %0d", d, cyc, d ? ww1 : ww0);
      check("done_expected", 128'(dq.size() != 0), 128'(1));
      if (dq.size() != 0) begin
        e = dq.pop_front();
        check("done_cycle", 128'(cyc), 128'(e.cyc));
        check("done_dut", 128'(d), 128'(e.d));
        check("done_words_written", 128'(d ? ww1 : ww0), 128'(e.data[6:0]));
        check("done_busy", 128'(d ? busy1 : busy0), 128'(1));
        check("done_not_ready", 128'(d ? kr1 : kr0), 128'(0));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input bit d, input logic [127:0] k, output int t);
    int waited;
    waited = 0;
    if (d) begin kv1 = 1'b1; mk1 = k; end
    else   begin kv0 = 1'b1; mk0 = k; end
    while (!(d ? kr1 : kr0) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("accept_in_time", 128'(d ? kr1 : kr0), 128'(1));
    t = cyc;
    $display("accept dut%0d cycle %0d key %032h", d, t, k);
    model_push(d, k, t);
    @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic post_check(input bit d, input int t);
    int n;
    n = d ? 4 : 16;
    wait_until(t + n + 2);
    check("ready_returns", 128'(d ? kr1 : kr0), 128'(1));
    check("idle_not_busy", 128'(d ? busy1 : busy0), 128'(0));
    check("idle_no_write", 128'(d ? we1 : we0), 128'(0));
    check("idle_words_written", 128'(d ? ww1 : ww0), 128'(n));
  endtask

  task automatic check_key_words(input string name, input int base, input logic [127:0] k);
    check(name, {mem[base], mem[base+1], mem[base+2], mem[base+3]}, k);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin : stim
    int t, t2;
    wr_t tmp[$];
    rst = 1'b1; kv0 = 1'b0; kv1 = 1'b0; mk0 = '0; mk1 = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    @(negedge clk);
    @(negedge clk);
    // rst and key_valid together: reset wins
    kv0 = 1'b1; mk0 = {4{32'hDEADBEEF}};
    @(negedge clk);
    check("rst_key_ready", 128'(kr0), 128'(1));
    check("rst_busy", 128'(busy0), 128'(0));
    check("rst_we", 128'(we0), 128'(0));
    check("rst_done", 128'(done0), 128'(0));
    check("rst_addr", 128'(addr0), 128'(0));
    check("rst_data", 128'(data0), 128'(0));
    check("rst_ww", 128'(ww0), 128'(0));
    check("rst_key_ready1", 128'(kr1), 128'(1));
    kv0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Basic load, 16 words
    send(0, 128'h00000001_00000002_00000003_00000004, t);
    kv0 = 1'b0;
    post_check(0, t);
    check_key_words("basic_words0to3", 0, 128'h00000001_00000002_00000003_00000004);
    check("basic_addr4", 128'(mem[4]), 128'(32'h00000405));
    check("basic_addr5", 128'(mem[5]), 128'(32'h00040507));

    // All-ones key
    send(0, {128{1'b1}}, t);
    kv0 = 1'b0;
    post_check(0, t);
    check_key_words("ones_words0to3", 0, {128{1'b1}});
    check("ones_addr4", 128'(mem[4]), 128'(32'h00000004));

    // Four words at the top of the cache
    send(1, 128'h11111111_22222222_33333333_44444444, t);
    kv1 = 1'b0;
    post_check(1, t);
    check_key_words("top_words60to63", 60, 128'h11111111_22222222_33333333_44444444);

    // key_valid held high with a changing key while busy
    send(0, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, t);
    while (cyc < t + 17) begin
      check("busy_not_ready", 128'(kr0), 128'(0));
      mk0 = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    send(0, 128'h01234567_89ABCDEF_FEDCBA98_76543210, t2);
    kv0 = 1'b0;
    check("second_accept_cycle", 128'(t2), 128'(t + 18));
    post_check(0, t2);
    check_key_words("second_key_words", 0, 128'h01234567_89ABCDEF_FEDCBA98_76543210);

    // Reset while addr 7 is being written
    send(0, 128'hCAFEBABE_12345678_9ABCDEF0_0BADF00D, t);
    kv0 = 1'b0;
    wait_until(t + 8);
    check("addr7_in_flight", 128'(addr0), 128'(7));
    rst = 1'b1;
    tmp = {};
    foreach (wq[i]) if (wq[i].cyc <= 32'(t + 8)) tmp.push_back(wq[i]);
    wq = tmp;
    dq.delete();
    @(negedge clk);
    rst = 1'b0;
    check("midrst_we", 128'(we0), 128'(0));
    check("midrst_ready", 128'(kr0), 128'(1));
    check("midrst_done", 128'(done0), 128'(0));
    check("midrst_busy", 128'(busy0), 128'(0));
    check("midrst_ww", 128'(ww0), 128'(0));
    repeat (20) @(negedge clk);
    send(0, 128'h00000010_00000020_00000030_00000040, t);
    kv0 = 1'b0;
    post_check(0, t);
    check_key_words("reload_words0to3", 0, 128'h00000010_00000020_00000030_00000040);

    repeat (4) @(negedge clk);
    check("writes_drained", 128'(wq.size()), 128'(0));
    check("dones_drained", 128'(dq.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
